// File: rtl/sram_host_ctrl.sv
// Burst read/write initiator for the 8x8 single-port SRAM: one SRAM access per beat,
// valid/ready handshakes on command, write-data and read-response ports.
module sram_host_ctrl #(
   parameter int AW    = 8,
   parameter int DW    = 8,
   parameter int DEPTH = 8,
   parameter int LW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic [AW-1:0] req_addr,
   input  logic [LW-1:0] req_len,
   input  logic          wdata_valid,
   output logic          wdata_ready,
   input  logic [DW-1:0] wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_last,
   output logic          done,
   output logic          err,
   output logic          sram_cs,
   output logic          sram_we,
   output logic          sram_rd,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_din,
   input  logic [DW-1:0] sram_dout
);

   localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] MASK    = AW'(DEPTH-1);

   typedef enum logic [2:0] {
      IDLE, WR_WAIT, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_RESP, DONE
   } state_t;

   state_t        state, state_d;
   logic [AW-1:0] cur, cur_d;
   logic [LW-1:0] cnt, cnt_d;
   logic [DW-1:0] wbuf, wbuf_d;
   logic [DW-1:0] rsp_data_d;

   logic          req_ready_d, wdata_ready_d, rsp_valid_d, rsp_last_d;
   logic          done_d, err_d, sram_cs_d, sram_we_d, sram_rd_d;
   logic [AW-1:0] sram_addr_d;
   logic [DW-1:0] sram_din_d;

   logic          last;
   logic [AW-1:0] cur_inc;

   assign last    = (cnt == '0);
   assign cur_inc = (cur + 1'b1) & MASK;

   // State, datapath and all outputs are registered together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cur         <= '0;
         cnt         <= '0;
         wbuf        <= '0;
         rsp_data    <= '0;
         req_ready   <= 1'b0;
         wdata_ready <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_last    <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         sram_cs     <= 1'b0;
         sram_we     <= 1'b0;
         sram_rd     <= 1'b0;
         sram_addr   <= '0;
         sram_din    <= '0;
      end else begin
         state       <= state_d;
         cur         <= cur_d;
         cnt         <= cnt_d;
         wbuf        <= wbuf_d;
         rsp_data    <= rsp_data_d;
         req_ready   <= req_ready_d;
         wdata_ready <= wdata_ready_d;
         rsp_valid   <= rsp_valid_d;
         rsp_last    <= rsp_last_d;
         done        <= done_d;
         err         <= err_d;
         sram_cs     <= sram_cs_d;
         sram_we     <= sram_we_d;
         sram_rd     <= sram_rd_d;
         sram_addr   <= sram_addr_d;
         sram_din    <= sram_din_d;
      end
   end

   always_comb begin
      state_d    = state;
      cur_d      = cur;
      cnt_d      = cnt;
      wbuf_d     = wbuf;
      rsp_data_d = rsp_data;
      unique case (state)
         IDLE: begin
            // req_ready gates acceptance: it is still 0 in the first cycle after reset.
            if (req_valid && req_ready) begin
               cur_d = req_addr;
               cnt_d = req_len;
               if ({1'b0, req_addr} >= DEPTH_W) state_d = DONE;
               else if (req_write)             state_d = WR_WAIT;
               else                            state_d = RD_ISSUE;
            end
         end
         WR_WAIT: begin
            if (wdata_valid) begin
               wbuf_d  = wdata;
               state_d = WR_ISSUE;
            end
         end
         WR_ISSUE: begin
            if (last) state_d = DONE;
            else begin
               cnt_d   = cnt - 1'b1;
               cur_d   = cur_inc;
               state_d = WR_WAIT;
            end
         end
         RD_ISSUE: state_d = RD_WAIT;
         RD_WAIT: begin
            rsp_data_d = sram_dout;
            state_d    = RD_RESP;
         end
         RD_RESP: begin
            if (rsp_ready) begin
               if (last) state_d = DONE;
               else begin
                  cnt_d   = cnt - 1'b1;
                  cur_d   = cur_inc;
                  state_d = RD_ISSUE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_comb begin
      req_ready_d   = (state_d == IDLE);
      wdata_ready_d = (state_d == WR_WAIT);
      sram_we_d     = (state_d == WR_ISSUE);
      sram_rd_d     = (state_d == RD_ISSUE);
      sram_cs_d     = sram_we_d | sram_rd_d;
      sram_addr_d   = sram_cs_d ? cur_d : '0;
      sram_din_d    = sram_we_d ? wbuf_d : '0;
      rsp_valid_d   = (state_d == RD_RESP);
      rsp_last_d    = (state_d == RD_RESP) && (cnt_d == '0);
      done_d        = (state_d == DONE);
      // DONE straight from IDLE only happens for a rejected command.
      err_d         = (state_d == DONE) && (state == IDLE);
   end

endmodule

// File: tb/tb_sram_host_ctrl.sv
// Directed bench for sram_host_ctrl with a behavioural 8x8 registered-read SRAM.
module tb_sram_host_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 0, req_write = 0;
   logic [7:0] req_addr = '0;
   logic [2:0] req_len = '0;
   logic       wdata_valid = 0;
   logic [7:0] wdata = '0;
   logic       rsp_ready = 0;
   logic       req_ready, wdata_ready, rsp_valid, rsp_last, done, err;
   logic       sram_cs, sram_we, sram_rd;
   logic [7:0] rsp_data, sram_addr, sram_din;
   logic [7:0] sram_dout = '0;

   int tests = 0, fails = 0;
   int wr_n = 0, rd_n = 0, done_n = 0, err_n = 0, inv_n = 0;
   logic [15:0] wlog[$];
   logic [7:0]  mem [8];
   logic [7:0]  got_d [$];
   logic        got_l [$];
   int base_w, base_r, base_d;

   always #5 clk = ~clk;

   sram_host_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
      .done(done), .err(err),
      .sram_cs(sram_cs), .sram_we(sram_we), .sram_rd(sram_rd),
      .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
   );

   // SRAM model plus event monitor; samples the strobes as the SRAM sees them.
   always @(posedge clk) begin
      if (sram_cs && sram_we) mem[sram_addr[2:0]] <= sram_din;
      if (sram_cs && sram_rd) sram_dout <= mem[sram_addr[2:0]];
      if (!rst) begin
         if (sram_cs && sram_we) begin wr_n++; wlog.push_back({sram_addr, sram_din}); end
         if (sram_cs && sram_rd) rd_n++;
         if (done) done_n++;
         if (done && err) err_n++;
      end
      if ((sram_we && sram_rd) || ((sram_we || sram_rd) && !sram_cs)) inv_n++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [32:0] outs();
      return {req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, done, err,
              sram_cs, sram_we, sram_rd, sram_addr, sram_din};
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   // Present a command and return in the cycle after the accepting edge.
   task automatic send_cmd(input logic w, input logic [7:0] a, input logic [2:0] l);
      req_valid = 1; req_write = w; req_addr = a; req_len = l;
      for (int i = 0; i < 50 && !req_ready; i++) step();
      chk("req_ready_wait", req_ready, 1);
      step();
      req_valid = 0;
   endtask

   task automatic put_beat(input logic [7:0] d);
      for (int i = 0; i < 50 && !wdata_ready; i++) step();
      chk("wdata_ready_wait", wdata_ready, 1);
      wdata_valid = 1; wdata = d;
      step();
      wdata_valid = 0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100 && !done; i++) step();
      chk("done_wait", done, 1);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = '0;
      // Reset held three cycles
      for (int i = 0; i < 3; i++) begin step(); chk("rst_outs", outs(), 0); end
      rst = 0;
      chk("ready_before_edge", req_ready, 0);
      step();
      chk("ready_after_release", req_ready, 1);
      chk("idle_outs", outs(), 33'h1_0000_0000);

      // Single write, then single read of addr 3
      base_w = wr_n; base_r = rd_n; base_d = done_n;
      send_cmd(1, 8'd3, 3'd0);
      chk("wr_wdata_ready", wdata_ready, 1);
      chk("wr_req_ready_busy", req_ready, 0);
      wdata_valid = 1; wdata = 8'hA5;
      step();
      wdata_valid = 0;
      chk("wr_issue_strobes", {sram_cs, sram_we, sram_rd}, 3'b110);
      chk("wr_issue_addr", sram_addr, 8'd3);
      chk("wr_issue_din", sram_din, 8'hA5);
      step();
      chk("wr_done", {done, err}, 2'b10);
      chk("wr_cs_off", sram_cs, 0);
      step();
      chk("wr_back_idle", {done, req_ready}, 2'b01);

      send_cmd(0, 8'd3, 3'd0);
      chk("rd_issue_strobes", {sram_cs, sram_we, sram_rd}, 3'b101);
      chk("rd_issue_addr", sram_addr, 8'd3);
      step();
      chk("rd_wait", {rsp_valid, sram_cs}, 2'b00);
      step();
      chk("rd_rsp", {rsp_valid, rsp_last, rsp_data}, {2'b11, 8'hA5});
      rsp_ready = 1;
      step();
      rsp_ready = 0;
      chk("rd_done", {done, err, rsp_valid, rsp_last}, 4'b1000);
      step();
      chk("single_counts", {8'(wr_n - base_w), 8'(rd_n - base_r), 8'(done_n - base_d)},
          {8'd1, 8'd1, 8'd2});

      // 4-beat write wrapping 6,7,0,1 and read back
      wlog.delete();
      send_cmd(1, 8'd6, 3'd3);
      put_beat(8'h11); put_beat(8'h22); put_beat(8'h33); put_beat(8'h44);
      wait_done();
      step();
      chk("burst_wr_count", wlog.size(), 4);
      if (wlog.size() == 4) begin
         chk("burst_wr_0", wlog[0], 16'h0611);
         chk("burst_wr_1", wlog[1], 16'h0722);
         chk("burst_wr_2", wlog[2], 16'h0033);
         chk("burst_wr_3", wlog[3], 16'h0144);
      end

      base_r = rd_n;
      rsp_ready = 1;
      send_cmd(0, 8'd6, 3'd3);
      for (int i = 0; i < 100 && !done; i++) begin
         if (rsp_valid) begin got_d.push_back(rsp_data); got_l.push_back(rsp_last); end
         step();
      end
      rsp_ready = 0;
      chk("burst_rd_done", done, 1);
      chk("burst_rd_beats", got_d.size(), 4);
      if (got_d.size() == 4)
         chk("burst_rd_data", {got_d[0], got_d[1], got_d[2], got_d[3]}, 32'h11223344);
      if (got_l.size() == 4)
         chk("burst_rd_last", {got_l[0], got_l[1], got_l[2], got_l[3]}, 4'b0001);
      chk("burst_rd_reads", rd_n - base_r, 4);
      step();

      // Stalled read len=1 at addr 0
      base_r = rd_n;
      send_cmd(0, 8'd0, 3'd1);
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 50 && !rsp_valid; i++) step();
         for (int i = 0; i < 5; i++) begin
            chk("stall_hold", {rsp_valid, rsp_last, rsp_data},
                {1'b1, (b == 1), (b == 0) ? 8'h33 : 8'h44});
            chk("stall_no_cs", sram_cs, 0);
            step();
         end
         chk("stall_reads", rd_n - base_r, b + 1);
         rsp_ready = 1;
         step();
         rsp_ready = 0;
      end
      wait_done();
      chk("stall_total_reads", rd_n - base_r, 2);
      step();

      // Out-of-range command
      base_w = wr_n; base_d = err_n;
      send_cmd(1, 8'd9, 3'd0);
      chk("err_pulse", {done, err, sram_cs, wdata_ready}, 4'b1100);
      step();
      chk("err_idle", {done, err, req_ready}, 3'b001);
      chk("err_counts", {8'(wr_n - base_w), 8'(err_n - base_d)}, {8'd0, 8'd1});

      // Reset during the second beat wait of a 4-beat write
      wlog.delete();
      base_d = done_n;
      send_cmd(1, 8'd2, 3'd3);
      put_beat(8'h5A);
      for (int i = 0; i < 50 && !wdata_ready; i++) step();
      chk("mid_wr_wait", wdata_ready, 1);
      #2 rst = 1;
      #1 chk("async_rst_outs", outs(), 0);
      step(); step();
      rst = 0;
      step();
      chk("post_rst_writes", wlog.size(), 1);
      if (wlog.size() == 1) chk("post_rst_wlog", wlog[0], 16'h025A);
      chk("post_rst_no_done", done_n - base_d, 0);
      send_cmd(0, 8'd2, 3'd0);
      for (int i = 0; i < 50 && !rsp_valid; i++) step();
      chk("post_rst_read", {rsp_valid, rsp_data}, {1'b1, 8'h5A});
      rsp_ready = 1;
      step();
      rsp_ready = 0;
      chk("post_rst_done", done, 1);
      step();

      chk("strobe_invariants", inv_n, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
